controle_multiciclo: RTL and testbench

CONTROLE_MULTICICLO -- requirements
Module: controle_multiciclo

---
 rtl/controle_multiciclo_pkg.sv | 54 +++++
 rtl/ctrl_wait_cnt.sv | 25 ++
 rtl/controle_multiciclo.sv | 245 ++++++++++++++++++++++++
 tb/tb_controle_multiciclo.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/controle_multiciclo_pkg.sv
// rtl/controle_multiciclo_pkg.sv - shared state, opcode/funct and control-field encodings
package controle_multiciclo_pkg;

    typedef enum logic [4:0] {
        ST_FETCH  = 5'd0,
        ST_FWAIT  = 5'd1,
        ST_DECODE = 5'd2,
        ST_EXEC_R = 5'd3,
        ST_WB_R   = 5'd4,
        ST_EXEC_I = 5'd5,
        ST_WB_I   = 5'd6,
        ST_MADDR  = 5'd7,
        ST_MRD    = 5'd8,
        ST_MWAIT  = 5'd9,
        ST_WB_LW  = 5'd10,
        ST_MWR    = 5'd11,
        ST_BRANCH = 5'd12,
        ST_JUMP   = 5'd13,
        ST_EXC    = 5'd14
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_FUNCT = 3'd2;
    localparam logic [2:0] ALU_SLT   = 3'd3;

    localparam logic [2:0] PCS_ALU    = 3'd0;
    localparam logic [2:0] PCS_ALUOUT = 3'd1;
    localparam logic [2:0] PCS_JUMP   = 3'd2;

    localparam logic [1:0] EXC_NONE    = 2'd0;
    localparam logic [1:0] EXC_ILLEGAL = 2'd1;
    localparam logic [1:0] EXC_OVF     = 2'd2;

    function automatic logic funct_supported(input logic [5:0] fn);
        return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) || (fn == FN_SLT);
    endfunction

endpackage

// File: rtl/ctrl_wait_cnt.sv
// rtl/ctrl_wait_cnt.sv - memory wait-state down-counter with load, decrement and done flag
module ctrl_wait_cnt (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       done
);

    logic [3:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != 4'd0)) begin
            count <= count - 4'd1;
        end
    end

    assign done = (count == 4'd0);

endmodule

// File: rtl/controle_multiciclo.sv
// rtl/controle_multiciclo.sv - multicycle MIPS-style control FSM; CTRL_OVF_EXC_EN enables overflow exceptions
module controle_multiciclo
    import controle_multiciclo_pkg::*;
#(
    parameter int         MEM_WAIT       = 1,
    parameter logic [2:0] EXC_VECTOR_SEL = 3'b011
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       branch_ne,
    output logic       iord,
    output logic       mem_wr,
    output logic       ir_write,
    output logic       reg_write,
    output logic       ab_write,
    output logic       aluout_write,
    output logic       epc_write,
    output logic [1:0] alu_src_a,
    output logic [2:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [2:0] pc_source,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic [1:0] exc_code,
    output logic [4:0] state
);

    localparam logic [4:0] FETCH  = ST_FETCH;
    localparam logic [4:0] FWAIT  = ST_FWAIT;
    localparam logic [4:0] DECODE = ST_DECODE;
    localparam logic [4:0] EXEC_R = ST_EXEC_R;
    localparam logic [4:0] WB_R   = ST_WB_R;
    localparam logic [4:0] EXEC_I = ST_EXEC_I;
    localparam logic [4:0] WB_I   = ST_WB_I;
    localparam logic [4:0] MADDR  = ST_MADDR;
    localparam logic [4:0] MRD    = ST_MRD;
    localparam logic [4:0] MWAIT  = ST_MWAIT;
    localparam logic [4:0] WB_LW  = ST_WB_LW;
    localparam logic [4:0] MWR    = ST_MWR;
    localparam logic [4:0] BRANCH = ST_BRANCH;
    localparam logic [4:0] JUMP   = ST_JUMP;
    localparam logic [4:0] EXC    = ST_EXC;

    localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT - 1);

    logic [4:0] cur_state;
    logic [4:0] next_state;
    logic       run;
    logic [5:0] ir_op;
    logic [1:0] exc_r;
    logic [1:0] exc_next;
    logic       cnt_load;
    logic       cnt_dec;
    logic       cnt_done;

    // zero is consumed by the datapath's branch gating, not by the sequencer
    logic unused_inputs;
`ifdef CTRL_OVF_EXC_EN
    logic ir_arith;
    assign unused_inputs = zero;
`else
    assign unused_inputs = zero ^ overflow;
`endif

    ctrl_wait_cnt u_wait (
        .clock    (clock),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (WAIT_LOAD),
        .dec      (cnt_dec),
        .done     (cnt_done)
    );

    always_comb begin
        next_state = cur_state;
        exc_next   = exc_r;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        case (cur_state)
            FETCH: begin
                next_state = FWAIT;
                cnt_load   = 1'b1;
            end
            FWAIT: begin
                if (cnt_done) next_state = DECODE;
                else          cnt_dec    = 1'b1;
            end
            DECODE: begin
                if (opcode == OP_RTYPE && funct_supported(funct)) begin
                    next_state = EXEC_R;
                end else if (opcode == OP_ADDI || opcode == OP_ADDIU || opcode == OP_SLTI) begin
                    next_state = EXEC_I;
                end else if (opcode == OP_LW || opcode == OP_SW) begin
                    next_state = MADDR;
                end else if (opcode == OP_BEQ || opcode == OP_BNE) begin
                    next_state = BRANCH;
                end else if (opcode == OP_J) begin
                    next_state = JUMP;
                end else begin
                    next_state = EXC;
                    exc_next   = EXC_ILLEGAL;
                end
            end
            EXEC_R, EXEC_I: begin
                next_state = (cur_state == EXEC_R) ? WB_R : WB_I;
`ifdef CTRL_OVF_EXC_EN
                if (overflow && ir_arith) begin
                    next_state = EXC;
                    exc_next   = EXC_OVF;
                end
`endif
            end
            MADDR: begin
                next_state = (ir_op == OP_LW) ? MRD : MWR;
                cnt_load   = 1'b1;
            end
            MRD: begin
                next_state = MWAIT;
                cnt_load   = 1'b1;
            end
            MWAIT: begin
                if (cnt_done) next_state = WB_LW;
                else          cnt_dec    = 1'b1;
            end
            MWR: begin
                if (cnt_done) next_state = FETCH;
                else          cnt_dec    = 1'b1;
            end
            default: next_state = FETCH;
        endcase
    end

    // run stays low for the first edge after reset so FETCH outputs start one edge later
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur_state <= FETCH;
            run       <= 1'b0;
            exc_r     <= EXC_NONE;
            ir_op     <= 6'd0;
        end else begin
            run <= 1'b1;
            if (run) begin
                cur_state <= next_state;
                exc_r     <= exc_next;
                if (cur_state == DECODE) ir_op <= opcode;
            end
        end
    end

`ifdef CTRL_OVF_EXC_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ir_arith <= 1'b0;
        end else if (run && cur_state == DECODE) begin
            ir_arith <= (opcode == OP_RTYPE && (funct == FN_ADD || funct == FN_SUB)) ||
                        (opcode == OP_ADDI);
        end
    end
`endif

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        iord          = 1'b0;
        mem_wr        = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        ab_write      = 1'b0;
        aluout_write  = 1'b0;
        epc_write     = 1'b0;
        alu_src_a     = 2'd0;
        alu_src_b     = 3'd0;
        alu_op        = ALU_ADD;
        pc_source     = PCS_ALU;
        reg_dst       = 2'd0;
        mem_to_reg    = 2'd0;
        if (run) begin
            case (cur_state)
                FETCH: begin
                    alu_src_b = 3'd1;
                    pc_write  = 1'b1;
                end
                FWAIT: ir_write = cnt_done;
                DECODE: begin
                    ab_write     = 1'b1;
                    aluout_write = 1'b1;
                    alu_src_b    = 3'd3;
                end
                EXEC_R: begin
                    alu_src_a    = 2'd1;
                    alu_op       = ALU_FUNCT;
                    aluout_write = 1'b1;
                end
                WB_R: begin
                    reg_dst   = 2'd1;
                    reg_write = 1'b1;
                end
                EXEC_I, MADDR: begin
                    alu_src_a    = 2'd1;
                    alu_src_b    = 3'd2;
                    alu_op       = (cur_state == EXEC_I && ir_op == OP_SLTI) ? ALU_SLT : ALU_ADD;
                    aluout_write = 1'b1;
                end
                WB_I: reg_write = 1'b1;
                MRD: iord = 1'b1;
                WB_LW: begin
                    mem_to_reg = 2'd1;
                    reg_write  = 1'b1;
                end
                MWR: begin
                    iord   = 1'b1;
                    mem_wr = 1'b1;
                end
                BRANCH: begin
                    alu_src_a     = 2'd1;
                    alu_op        = ALU_SUB;
                    pc_write_cond = 1'b1;
                    pc_source     = PCS_ALUOUT;
                    branch_ne     = (ir_op == OP_BNE);
                end
                JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = PCS_JUMP;
                end
                EXC: begin
                    epc_write = 1'b1;
                    pc_write  = 1'b1;
                    pc_source = EXC_VECTOR_SEL;
                end
                default: ;
            endcase
        end
    end

    assign exc_code = exc_r;
    assign state    = cur_state;

endmodule

// File: tb/tb_controle_multiciclo.sv
// tb/tb_controle_multiciclo.sv - randomized trace-model bench for controle_multiciclo (MEM_WAIT 1 and 3)
module tb_controle_multiciclo;
    import controle_multiciclo_pkg::*;

`ifdef CTRL_OVF_EXC_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    typedef struct {
        logic [4:0] st;
        logic       last;
        logic [1:0] code;
    } item_t;

    logic        clock = 1'b0;
    logic        rst       [2];
    logic [5:0]  opcode    [2];
    logic [5:0]  funct     [2];
    logic        zero      [2];
    logic        overflow  [2];
    logic        pc_write [2], pc_write_cond [2], branch_ne [2], iord [2], mem_wr [2];
    logic        ir_write [2], reg_write [2], ab_write [2], aluout_write [2], epc_write [2];
    logic [1:0]  alu_src_a [2], reg_dst [2], mem_to_reg [2], exc_code [2];
    logic [2:0]  alu_src_b [2], alu_op [2], pc_source [2];
    logic [4:0]  state     [2];
    logic [24:0] outs      [2];
    logic [1:0]  exp_exc   [2];

    int vectors = 0;
    int errors  = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        controle_multiciclo #(.MEM_WAIT(g == 0 ? 1 : 3)) dut (
            .clock(clock), .reset(rst[g]), .opcode(opcode[g]), .funct(funct[g]),
            .zero(zero[g]), .overflow(overflow[g]),
            .pc_write(pc_write[g]), .pc_write_cond(pc_write_cond[g]), .branch_ne(branch_ne[g]),
            .iord(iord[g]), .mem_wr(mem_wr[g]), .ir_write(ir_write[g]), .reg_write(reg_write[g]),
            .ab_write(ab_write[g]), .aluout_write(aluout_write[g]), .epc_write(epc_write[g]),
            .alu_src_a(alu_src_a[g]), .alu_src_b(alu_src_b[g]), .alu_op(alu_op[g]),
            .pc_source(pc_source[g]), .reg_dst(reg_dst[g]), .mem_to_reg(mem_to_reg[g]),
            .exc_code(exc_code[g]), .state(state[g])
        );
        assign outs[g] = {pc_write[g], pc_write_cond[g], branch_ne[g], iord[g], mem_wr[g],
                          ir_write[g], reg_write[g], ab_write[g], aluout_write[g], epc_write[g],
                          alu_src_a[g], alu_src_b[g], alu_op[g], pc_source[g], reg_dst[g], mem_to_reg[g]};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Control-word table, one row per state as the instruction set defines it
    function automatic logic [24:0] exp_outs(input logic [4:0] st, input logic last, input logic [5:0] op);
        logic pw, pwc, bne, io, mw, irw, rw, abw, aow, epw;
        logic [1:0] sa, rd, m2r;
        logic [2:0] sb, ao, ps;
        {pw, pwc, bne, io, mw, irw, rw, abw, aow, epw} = '0;
        sa = 0; rd = 0; m2r = 0; sb = 0; ao = 0; ps = 0;
        case (st)
            ST_FETCH:  begin pw = 1; sb = 1; end
            ST_FWAIT:  irw = last;
            ST_DECODE: begin abw = 1; aow = 1; sb = 3; end
            ST_EXEC_R: begin sa = 1; ao = 2; aow = 1; end
            ST_WB_R:   begin rd = 1; rw = 1; end
            ST_EXEC_I: begin sa = 1; sb = 2; ao = (op == 6'h0A) ? 3'd3 : 3'd0; aow = 1; end
            ST_WB_I:   rw = 1;
            ST_MADDR:  begin sa = 1; sb = 2; aow = 1; end
            ST_MRD:    io = 1;
            ST_WB_LW:  begin m2r = 1; rw = 1; end
            ST_MWR:    begin io = 1; mw = 1; end
            ST_BRANCH: begin sa = 1; ao = 1; pwc = 1; ps = 1; bne = (op == 6'h05); end
            ST_JUMP:   begin pw = 1; ps = 2; end
            ST_EXC:    begin epw = 1; pw = 1; ps = 3; end
            default: ;
        endcase
        return {pw, pwc, bne, io, mw, irw, rw, abw, aow, epw, sa, sb, ao, ps, rd, m2r};
    endfunction

    task automatic build(input int mwait, input logic [5:0] op, input logic [5:0] fn,
                         input logic ovf, output item_t tr[$]);
        bit r_ok, arith;
        tr = {};
        tr.push_back('{ST_FETCH, 1'b0, 2'd0});
        for (int i = 0; i < mwait; i++) tr.push_back('{ST_FWAIT, (i == mwait - 1), 2'd0});
        tr.push_back('{ST_DECODE, 1'b0, 2'd0});
        r_ok  = (op == 6'h00) && (fn inside {6'h20, 6'h22, 6'h24, 6'h2A});
        arith = (op == 6'h08) || ((op == 6'h00) && (fn inside {6'h20, 6'h22}));
        if (r_ok || op inside {6'h08, 6'h09, 6'h0A}) begin
            tr.push_back('{r_ok ? ST_EXEC_R : ST_EXEC_I, 1'b0, 2'd0});
            if (OVF_EN && ovf && arith) tr.push_back('{ST_EXC, 1'b0, 2'd2});
            else tr.push_back('{r_ok ? ST_WB_R : ST_WB_I, 1'b0, 2'd0});
        end else if (op == 6'h23) begin
            tr.push_back('{ST_MADDR, 1'b0, 2'd0});
            tr.push_back('{ST_MRD, 1'b0, 2'd0});
            for (int i = 0; i < mwait; i++) tr.push_back('{ST_MWAIT, 1'b0, 2'd0});
            tr.push_back('{ST_WB_LW, 1'b0, 2'd0});
        end else if (op == 6'h2B) begin
            tr.push_back('{ST_MADDR, 1'b0, 2'd0});
            for (int i = 0; i < mwait; i++) tr.push_back('{ST_MWR, 1'b0, 2'd0});
        end else if (op inside {6'h04, 6'h05}) begin
            tr.push_back('{ST_BRANCH, 1'b0, 2'd0});
        end else if (op == 6'h02) begin
            tr.push_back('{ST_JUMP, 1'b0, 2'd0});
        end else begin
            tr.push_back('{ST_EXC, 1'b0, 2'd1});
        end
    endtask

    task automatic check_idle(input int g, input string tag);
        chk({tag, "_state"}, 32'(state[g]), 32'(ST_FETCH));
        chk({tag, "_outs"}, 32'(outs[g]), 32'd0);
        chk({tag, "_exc"}, 32'(exc_code[g]), 32'd0);
    endtask

    task automatic do_reset(input int g);
        @(negedge clock);
        rst[g] = 1'b0;
        #1;
        check_idle(g, "rst");
        exp_exc[g] = 2'd0;
        @(negedge clock);
        rst[g] = 1'b1;
    endtask

    task automatic run_instr(input int g, input logic [5:0] op, input logic [5:0] fn,
                             input logic ovf, input logic z, input int abort_idx);
        item_t tr[$];
        string tag;
        opcode[g] = op; funct[g] = fn; overflow[g] = ovf; zero[g] = z;
        build(g == 0 ? 1 : 3, op, fn, ovf, tr);
        for (int i = 0; i < tr.size(); i++) begin
            @(negedge clock);
            if (tr[i].st == ST_EXC) exp_exc[g] = tr[i].code;
            tag = $sformatf("d%0d op%02h fn%02h c%0d", g, op, fn, i);
            chk({tag, " state"}, 32'(state[g]), 32'(tr[i].st));
            chk({tag, " outs"}, 32'(outs[g]), 32'(exp_outs(tr[i].st, tr[i].last, op)));
            chk({tag, " exc"}, 32'(exc_code[g]), 32'(exp_exc[g]));
            if (i == abort_idx) begin
                #2 rst[g] = 1'b0;
                #1 check_idle(g, "midrst");
                exp_exc[g] = 2'd0;
                @(negedge clock);
                rst[g] = 1'b1;
                #1 check_idle(g, "release");
                return;
            end
        end
    endtask

    function automatic logic [5:0] pick_op();
        logic [5:0] tbl [12] = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h04, 6'h05,
                                 6'h08, 6'h09, 6'h0A, 6'h23, 6'h2B, 6'h00};
        int k = $urandom_range(0, 12);
        return (k == 12) ? 6'($urandom_range(0, 63)) : tbl[k];
    endfunction

    function automatic logic [5:0] pick_fn();
        logic [5:0] tbl [4] = '{6'h20, 6'h22, 6'h24, 6'h2A};
        int k = $urandom_range(0, 4);
        return (k == 4) ? 6'($urandom_range(0, 63)) : tbl[k];
    endfunction

    initial begin
        for (int g = 0; g < 2; g++) begin
            rst[g] = 1'b0; opcode[g] = '0; funct[g] = '0; zero[g] = 1'b0; overflow[g] = 1'b0;
            exp_exc[g] = 2'd0;
        end
        #1;
        check_idle(0, "por0");
        check_idle(1, "por1");

        do_reset(0);
        run_instr(0, 6'h00, 6'h20, 1'b0, 1'b0, -1);
        run_instr(0, 6'h05, 6'h00, 1'b0, 1'b0, -1);
        run_instr(0, 6'h3F, 6'h00, 1'b0, 1'b0, -1);
        run_instr(0, 6'h08, 6'h00, 1'b1, 1'b0, -1);
        run_instr(0, 6'h00, 6'h22, 1'b1, 1'b1, -1);
        run_instr(0, 6'h00, 6'h24, 1'b1, 1'b0, -1);
        run_instr(0, 6'h00, 6'h3E, 1'b0, 1'b0, -1);
        run_instr(0, 6'h0A, 6'h00, 1'b0, 1'b0, -1);
        run_instr(0, 6'h2B, 6'h00, 1'b0, 1'b0, -1);
        run_instr(0, 6'h02, 6'h00, 1'b0, 1'b0, -1);
        for (int n = 0; n < 60; n++)
            run_instr(0, pick_op(), pick_fn(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);

        do_reset(1);
        run_instr(1, 6'h23, 6'h00, 1'b0, 1'b0, -1);
        run_instr(1, 6'h2B, 6'h00, 1'b0, 1'b0, -1);
        run_instr(1, 6'h3F, 6'h00, 1'b0, 1'b0, -1);
        run_instr(1, 6'h23, 6'h00, 1'b0, 1'b0, 8);
        run_instr(1, 6'h08, 6'h00, 1'b1, 1'b0, -1);
        for (int n = 0; n < 60; n++)
            run_instr(1, pick_op(), pick_fn(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
